// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential divider: operation encoding, adder op and
// small decode helpers.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } divOp_t;

    typedef enum logic {
        ADD_OP_ADD = 1'b0,
        ADD_OP_SUB = 1'b1
    } adderOp_t;

    function automatic logic op_is_signed(divOp_t o);
        return (o == DIV_DIV) || (o == DIV_REM);
    endfunction

    function automatic logic op_is_rem(divOp_t o);
        return (o == DIV_REM) || (o == DIV_REMU);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The partial remainder is always below the divisor, so the low WIDTH bits
    // of the difference are exact whenever the subtraction is taken.
    assign shifted    = {rem_in, dvd_bit};
    assign q_bit_c    = (shifted >= {1'b0, divisor});
    assign diff       = shifted[WIDTH-1:0] - divisor;
    assign rem_next_c = q_bit_c ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider with valid/ready request and response.
// Optional macro SEQ_DIVIDER_EARLY_OUT_EN short-cuts divide-by-zero and signed overflow.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  divOp_t           op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    divOp_t           op_q;
    logic             q_neg;
    logic             r_neg;
    logic             div_zero;

    logic             sgn_c;
    logic             div_zero_c;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    logic [WIDTH-1:0] step_rem_c;
    logic             step_q_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    // Operand decode at acceptance: magnitudes for signed ops
    assign sgn_c      = op_is_signed(op);
    assign div_zero_c = (divisor == '0);
    assign dvd_mag_c  = (sgn_c && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag_c  = (sgn_c && divisor[WIDTH-1])  ? -divisor  : divisor;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    logic             ovf_c;
    logic [WIDTH-1:0] early_res_c;

    assign ovf_c = sgn_c && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    assign early_res_c = op_is_rem(op) ? (div_zero_c ? dividend : '0)
                                       : (div_zero_c ? '1 : dividend);
`endif

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in     (rem),
        .dvd_bit    (quo[WIDTH-1]),
        .divisor    (dvsr),
        .rem_next_c (step_rem_c),
        .q_bit_c    (step_q_c)
    );

    // Sign correction; a zero divisor always yields an all-ones quotient
    assign quo_fix_c = div_zero ? '1 : (q_neg ? -quo : quo);
    assign rem_fix_c = r_neg ? -rem : rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            op_q       <= DIV_DIV;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div_zero   <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= op;
                        rem       <= '0;
                        quo       <= dvd_mag_c;
                        dvsr      <= dvs_mag_c;
                        q_neg     <= sgn_c && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg     <= sgn_c && dividend[WIDTH-1];
                        div_zero  <= div_zero_c;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                        if (div_zero_c || ovf_c) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            result     <= early_res_c;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem <= step_rem_c;
                    quo <= {quo[WIDTH-2:0], step_q_c};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    result     <= op_is_rem(op_q) ? rem_fix_c : quo_fix_c;
                end
                DONE: begin
                    // Retire; req_ready returns only on the following cycle
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        result     <= '0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): vector table, random ops with a
// reference model, response backpressure and mid-calculation reset.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    divOp_t       op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        divOp_t       o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .dividend   (dividend),
        .divisor    (divisor),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input divOp_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic sgn;
        sgn = (o == DIV_DIV) || (o == DIV_REM);
        if (b == '0) return ((o == DIV_REM) || (o == DIV_REMU)) ? a : '1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (o == DIV_DIV) ? a : '0;
        case (o)
            DIV_DIV:  return $signed(a) / $signed(b);
            DIV_REM:  return $signed(a) % $signed(b);
            DIV_DIVU: return a / b;
            default:  return a % b;
        endcase
    endfunction

    function automatic int exp_latency(input divOp_t o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (b == '0) return 1;
        if (((o == DIV_DIV) || (o == DIV_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return W + 2;
    endfunction

    // Issue one request, scramble inputs after acceptance, check latency,
    // optional backpressure, result via scoreboard and retirement behaviour.
    task automatic run_op(input divOp_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input int hold);
        int n;
        logic [W-1:0] first;
        logic [W-1:0] want;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 64'(req_ready), 64'(1));
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        op         = o;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        sb.push_back(exp_r);
        #1;
        req_valid = 1'b0;
        op        = DIV_DIVU;
        dividend  = ~a;
        divisor   = b + 32'd1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_after_accept", 64'(busy), 64'(1));
                check("req_ready_after_accept", 64'(req_ready), 64'(0));
            end
        end while (!resp_valid && n < 100);
        check("latency", 64'(n), 64'(exp_latency(o, a, b)));
        want = (sb.size() > 0) ? sb.pop_front() : ~exp_r;
        check("result", 64'(result), 64'(want));
        first = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", 64'(result), 64'(want));
            check("hold_valid", 64'(resp_valid), 64'(1));
            check("hold_req_ready", 64'(req_ready), 64'(0));
        end
        if (hold > 0) check("hold_stable", 64'(result), 64'(first));
        resp_ready = 1'b1;
        @(negedge clk);
        check("retire_valid", 64'(resp_valid), 64'(0));
        check("retire_result", 64'(result), 64'(0));
        check("retire_req_ready", 64'(req_ready), 64'(1));
    endtask

    initial begin
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        op         = DIV_DIVU;
        dividend   = '0;
        divisor    = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        vecs.push_back('{DIV_DIVU, 32'd100, 32'd7, 32'd14, 0});
        vecs.push_back('{DIV_REMU, 32'd100, 32'd7, 32'd2, 0});
        vecs.push_back('{DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0});
        vecs.push_back('{DIV_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0});
        vecs.push_back('{DIV_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0});
        vecs.push_back('{DIV_REMU, 32'd5, 32'd0, 32'd5, 0});
        vecs.push_back('{DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
        vecs.push_back('{DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0});
        vecs.push_back('{DIV_DIVU, 32'd100, 32'd7, 32'd14, 5});
        vecs.push_back('{DIV_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0});
        vecs.push_back('{DIV_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0});
        vecs.push_back('{DIV_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0});
        vecs.push_back('{DIV_DIV, 32'd0, 32'd5, 32'd0, 0});
        vecs.push_back('{DIV_REM, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 2});
        vecs.push_back('{DIV_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0});
        vecs.push_back('{DIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0});

        foreach (vecs[i]) run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);

        for (int i = 0; i < 16; i++) begin
            divOp_t       ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = divOp_t'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb), 0);
        end

        // Reset around iteration 10 of CALC; the in-flight op must vanish
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        op         = DIV_DIVU;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        check("midrst_resp_valid", 64'(resp_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        repeat (3) begin
            @(negedge clk);
            check("inrst_resp_valid", 64'(resp_valid), 64'(0));
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op(DIV_REMU, 32'd1000, 32'd7, 32'd6, 0);
        run_op(DIV_DIV, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 0);

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port op, input, divOp_t: operation, one of DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU.
REQ-007 SHALL have port dividend, input, WIDTH bits.
REQ-008 SHALL have port divisor, input, WIDTH bits.
REQ-009 SHALL have port resp_valid, output, 1 bit: result valid.
REQ-010 SHALL have port resp_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port result, output, WIDTH bits: quotient or remainder, as selected by op.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC, FIX and DONE.
REQ-014 SHALL drive req_ready high only in IDLE; a request is accepted on a rising edge with req_valid and req_ready both high.
REQ-015 SHALL latch op, dividend and divisor on acceptance; later input changes SHALL have no effect.
REQ-016 SHALL, for signed ops, latch operand magnitudes, the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
REQ-017 SHALL, in CALC, run exactly WIDTH restoring shift-subtract iterations, one per cycle, using a log2(WIDTH)+1-bit iteration counter; CALC->FIX after the last iteration.
REQ-018 SHALL, in FIX, spend one cycle applying two's-complement negation per the latched signs and selecting quotient or remainder; FIX->DONE.
REQ-019 SHALL assert resp_valid only in DONE, exactly WIDTH+2 cycles after the acceptance edge.
REQ-020 SHALL hold result stable while resp_valid is high and resp_ready is low; DONE->IDLE on the edge with resp_ready high.
REQ-021 SHALL NOT accept a new request in the same cycle as response retirement; req_ready rises the cycle after.
REQ-022 SHALL, for divisor 0, return quotient all-ones (every op) and remainder equal to the original dividend.
REQ-023 SHALL, for signed overflow (dividend 2^(WIDTH-1), divisor all-ones), return quotient equal to the dividend and remainder 0.
REQ-024 SHALL drive result to 0 whenever resp_valid is low.

Reset
REQ-025 SHALL, on rst_n low, immediately force state to IDLE, req_ready to 1, resp_valid to 0, busy to 0, result to 0, and clear the iteration counter and all datapath registers, including mid-CALC, FIX or DONE.
REQ-026 SHALL discard any in-flight operation on reset and produce no response for it.
REQ-027 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro SEQ_DIVIDER_EARLY_OUT_EN is defined, detect divide-by-zero and signed overflow at acceptance and go IDLE->DONE with results per REQ-022/023, with resp_valid asserted 1 cycle after acceptance.
REQ-029 SHALL, without that macro, route every operation through CALC and FIX with WIDTH+2-cycle latency; results are identical in both builds.

Structure
REQ-030 SHALL define divOp_t (DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU) in the shared package with adderOp_t; the FSM state enum stays local.
REQ-031 SHALL use exactly one sub-module, div_step: a combinational single restoring iteration taking partial remainder, dividend bit and divisor, and returning the new remainder and quotient bit.

Verification
REQ-032 SHALL cover DIVU 100/7, then REMU 100/7 with WIDTH=32: results 14 and 2; resp_valid 34 cycles after acceptance.
REQ-033 SHALL cover signed DIV -7/2 -> 0xFFFFFFFD (-3) and REM -7/2 -> 0xFFFFFFFF (-1).
REQ-034 SHALL cover DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; with SEQ_DIVIDER_EARLY_OUT_EN, latency is 1 cycle.
REQ-035 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0.
REQ-036 SHALL cover holding resp_ready low for 5 cycles in DONE: result stable, req_ready low; after retirement, req_ready high the next cycle.
REQ-037 SHALL cover asserting rst_n low at iteration 10 of CALC: outputs reach reset values immediately; the next request completes correctly with no stale response.
